// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: step-rate and pattern sequencer for a one-hot LED ring.
//
// A programmable prescaler sets the step rate. Four pattern modes are
// supported: rotate-left, rotate-right, ping-pong and blink-all. The block
// also has run/pause and single-step control. A new mode/divisor pair is
// taken over a valid/ready handshake and is applied only at a step boundary,
// so the LED pattern never shows an intermediate value.
//
// Ports
//   clk        clock
//   reset_n    asynchronous active-low reset
//   run        level: 1 = free-running, 0 = paused
//   step       one-cycle pulse, advances one position while paused
//   cfg_valid  configuration offer
//   cfg_ready  configuration slot free (registered)
//   cfg_mode   0 rotate-left, 1 rotate-right, 2 ping-pong, 3 blink-all
//   cfg_div    new prescaler divisor (one step every cfg_div+1 cycles)
//   leds       registered LED drive
//   tick       one-cycle pulse, coincident with each new leds value
//   mode       active pattern mode
module led_seq_ctrl #(
  parameter int unsigned NUM_LEDS    = 4,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                run,
  input  logic                step,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [1:0]          cfg_mode,
  input  logic [DIV_W-1:0]    cfg_div,
  output logic [NUM_LEDS-1:0] leds,
  output logic                tick,
  output logic [1:0]          mode
);

  localparam int unsigned MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_ROL   = 2'd0;
  localparam logic [MODE_W-1:0] MODE_ROR   = 2'd1;
  localparam logic [MODE_W-1:0] MODE_PING  = 2'd2;
  localparam logic [MODE_W-1:0] MODE_BLINK = 2'd3;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic {
    ST_PAUSED  = 1'b0,
    ST_RUNNING = 1'b1
  } state_t;

  // Pending configuration payload captured at handshake acceptance.
  typedef struct packed {
    logic [MODE_W-1:0] mode;
    logic [DIV_W-1:0]  div;
  } cfg_t;

  state_t state_q, state_d;

  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                dir_q, dir_d;
  logic                pend_valid_q, pend_valid_d;
  cfg_t                pend_q, pend_d;
  logic [NUM_LEDS-1:0] leds_d;
  logic                tick_d;
  logic [MODE_W-1:0]   mode_d;
  logic                cfg_ready_d;

  logic                terminal_c;
  logic                accept_c;
  logic                do_apply_c;
  logic                do_adv_c;
  logic [NUM_LEDS-1:0] adv_leds_c;
  logic                adv_dir_c;
  logic [NUM_LEDS-1:0] start_leds_c;
  logic [NUM_LEDS-1:0] rol_c;
  logic [NUM_LEDS-1:0] ror_c;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_PAUSED;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: run is sampled every cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PAUSED:  if (run)  state_d = ST_RUNNING;
      ST_RUNNING: if (!run) state_d = ST_PAUSED;
      default:    state_d = ST_PAUSED;
    endcase
  end

  // Pattern helpers: rotations keep a one-hot vector one-hot, including the
  // ping-pong endpoints where the direction flips instead of wrapping.
  always_comb begin
    rol_c      = {leds[NUM_LEDS-2:0], leds[NUM_LEDS-1]};
    ror_c      = {leds[0], leds[NUM_LEDS-1:1]};
    adv_leds_c = leds;
    adv_dir_c  = dir_q;
    case (mode)
      MODE_ROL: adv_leds_c = rol_c;
      MODE_ROR: adv_leds_c = ror_c;
      MODE_PING: begin
        if (dir_q == DIR_UP) begin
          if (leds[NUM_LEDS-1]) begin
            adv_leds_c = ror_c;
            adv_dir_c  = DIR_DOWN;
          end else begin
            adv_leds_c = rol_c;
          end
        end else begin
          if (leds[0]) begin
            adv_leds_c = rol_c;
            adv_dir_c  = DIR_UP;
          end else begin
            adv_leds_c = ror_c;
          end
        end
      end
      MODE_BLINK: adv_leds_c = (leds == '1) ? '0 : '1;
      default:    adv_leds_c = leds;
    endcase
  end

  // Start pattern for the mode about to be applied.
  always_comb begin
    start_leds_c = NUM_LEDS'(1);
    case (pend_q.mode)
      MODE_ROR:   start_leds_c = {1'b1, {(NUM_LEDS-1){1'b0}}};
      MODE_BLINK: start_leds_c = '1;
      default:    start_leds_c = NUM_LEDS'(1);
    endcase
  end

  // Output / datapath next-value logic.
  always_comb begin
    cnt_d        = cnt_q;
    div_d        = div_q;
    dir_d        = dir_q;
    pend_valid_d = pend_valid_q;
    pend_d       = pend_q;
    leds_d       = leds;
    tick_d       = 1'b0;
    mode_d       = mode;
    cfg_ready_d  = cfg_ready;
    do_apply_c   = 1'b0;
    do_adv_c     = 1'b0;

    terminal_c = (cnt_q == div_q);
    accept_c   = cfg_valid & cfg_ready;

    if (state_q == ST_RUNNING) begin
      // A pending config replaces the normal advance at terminal count.
      if (terminal_c) begin
        cnt_d      = '0;
        do_apply_c = pend_valid_q;
        do_adv_c   = ~pend_valid_q;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end else begin
      // While paused a pending config applies at once and beats a step.
      do_apply_c = pend_valid_q;
      do_adv_c   = ~pend_valid_q & step;
    end

    // Entering or staying in PAUSED keeps the prescaler cleared.
    if (state_d == ST_PAUSED) begin
      cnt_d = '0;
    end

    if (do_adv_c) begin
      leds_d = adv_leds_c;
      dir_d  = adv_dir_c;
      tick_d = 1'b1;
    end

    if (do_apply_c) begin
      mode_d       = pend_q.mode;
      div_d        = pend_q.div;
      cnt_d        = '0;
      dir_d        = DIR_UP;
      leds_d       = start_leds_c;
      tick_d       = 1'b1;
      pend_valid_d = 1'b0;
      cfg_ready_d  = 1'b1;
    end

    // cfg_ready is low whenever a config is pending, so acceptance never
    // coincides with an apply.
    if (accept_c) begin
      pend_d.mode  = cfg_mode;
      pend_d.div   = cfg_div;
      pend_valid_d = 1'b1;
      cfg_ready_d  = 1'b0;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      div_q        <= DIV_W'(DEFAULT_DIV);
      dir_q        <= DIR_UP;
      pend_valid_q <= 1'b0;
      pend_q       <= '0;
      leds         <= NUM_LEDS'(1);
      tick         <= 1'b0;
      mode         <= MODE_ROL;
      cfg_ready    <= 1'b1;
    end else begin
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      dir_q        <= dir_d;
      pend_valid_q <= pend_valid_d;
      pend_q       <= pend_d;
      leds         <= leds_d;
      tick         <= tick_d;
      mode         <= mode_d;
      cfg_ready    <= cfg_ready_d;
    end
  end

endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
Sequencing controller for the one-hot LED ring. It owns the step rate through a programmable prescaler and the pattern mode: rotate left, rotate right, ping-pong or blink-all. It also provides run/pause and single-step control. Software or a top-level config block loads a new mode and rate over a valid/ready handshake, and the change applies glitch-free at a step boundary.

Parameters:
NUM_LEDS, 4, LED count; legal values ≥2.
DIV_W, 16, prescaler divisor width.
DEFAULT_DIV, 3, divisor loaded at reset; one step every DEFAULT_DIV+1 cycles.

Ports:
clk  input  1  clock.
reset_n  input  1  asynchronous, active-low reset.
run  input  1  level; 1 = free-running stepping, 0 = paused.
step  input  1  one-cycle pulse; advances one position while paused.
cfg_valid  input  1  config offer.
cfg_ready  output  1  config slot free.
cfg_mode  input  2  0 rotate-left, 1 rotate-right, 2 ping-pong, 3 blink-all.
cfg_div  input  DIV_W  new divisor.
leds  output  NUM_LEDS  registered LED drive.
tick  output  1  one-cycle pulse, high in the same cycle an advanced leds value first appears.
mode  output  2  active mode.

Behaviour:
- Reset (async assert, sync release):
  - leds = 0…01, mode = 0, div = DEFAULT_DIV, cnt = 0.
  - dir = up, FSM = PAUSED, cfg_ready = 1, tick = 0, pending config cleared.
- FSM states and transitions:
  - PAUSED → RUNNING when run = 1 (sampled each cycle).
  - RUNNING → PAUSED when run = 0.
  - Entering PAUSED clears cnt to 0. leds hold their value.
- Prescaler (RUNNING only):
  - If cnt == div: next edge sets cnt = 0, advances leds, and drives tick = 1.
  - Otherwise cnt increments.
  - div = 0 gives a tick every cycle.
  - cnt never exceeds div.
- Step while PAUSED: step = 1 advances leds at the next edge with tick = 1. Step is ignored while RUNNING.
- Next-position rules (leds registered):
  - Mode 0: rotate left, MSB wraps to bit 0.
  - Mode 1: rotate right, bit 0 wraps to MSB.
  - Mode 2, dir up: shift left. At MSB, dir flips to down and the next step shifts right. At bit 0, dir flips to up.
    - 4-LED sequence: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010…
    - Endpoints are never repeated.
  - Mode 3: toggle between all-ones and all-zeros.
- Config handshake:
  - Accept when cfg_valid & cfg_ready. cfg_mode and cfg_div are captured into a pending register.
  - cfg_ready drops to 0 the cycle after acceptance and stays 0 until the pending config is applied.
  - RUNNING: apply on the next prescaler terminal count, in place of a normal advance.
  - PAUSED: apply on the cycle after acceptance.
  - On apply:
    - mode and div are updated, cnt = 0, dir = up, tick = 1.
    - leds = start pattern: 0…01 for modes 0 and 2, 10…0 for mode 1, all-ones for mode 3.
    - cfg_ready returns to 1 the cycle after apply.
- Simultaneous events:
  - Acceptance in the same cycle as a terminal count: that tick advances with the old mode, and the new config applies at the following terminal count.
  - step in the same cycle a pending config applies while PAUSED: the apply wins and the step is dropped.
  - run falling on a terminal-count cycle: the advance completes, then PAUSED.
- Reset mid-operation: any pending config is discarded and all state returns to reset values immediately.
- leds is always one-hot in modes 0–2 and all-ones or all-zeros in mode 3. No other value is ever driven.

Test Plan:
1. Reset, then run = 1 with div = 3 → tick every 4 cycles; leds 0001→0010→0100→1000→0001. tick is coincident with each change.
2. Config mode = 1, div = 0 while RUNNING → cfg_ready low until the next terminal count, then leds = 1000. Then 0100, 0010, 0001, 1000 on consecutive cycles.
3. Mode 2, div = 0, run 10 cycles → leds 0001,0010,0100,1000,0100,0010,0001,0010,0100,1000.
4. run = 0 mid-count, then three step pulses spaced apart → exactly three advances with three tick pulses. A step asserted while run = 1 causes no extra advance.
5. cfg_valid asserted on the terminal-count cycle with mode = 3 → that tick advances the old rotate. The next terminal count gives leds = 1111, then 0000, then 1111.
6. reset_n asserted asynchronously mid-run with a pending config → leds = 0001, mode = 0, cfg_ready = 1 immediately. The old config is never applied after release.
